// File: rtl/program_counter.sv
// Hack-platform program counter: one DFF per bit plus clear/jump/increment/hold next-state logic.
// Optional trace outputs (prev_out, changed) are built when PC_TRACE_EN is defined.

module program_counter_dff_bit #(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_BIT;
        end else begin
            q <= d;
        end
    end

endmodule

module program_counter #(
    parameter int unsigned       WIDTH        = 16,
    parameter logic [WIDTH-1:0]  RESET_VECTOR = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             inc,
    input  logic             sreset,
    input  logic             halt,
    output logic [WIDTH-1:0] out,
    output logic             wrapped
`ifdef PC_TRACE_EN
    ,
    output logic [WIDTH-1:0] prev_out,
    output logic             changed
`endif
);

    logic [WIDTH-1:0] pc_next;
    logic             wrap_next;

    always_comb begin
        pc_next   = out;
        wrap_next = 1'b0;
        if (sreset) begin
            pc_next = RESET_VECTOR;
        end else if (halt) begin
            pc_next = out;
        end else if (load) begin
            pc_next = in;
        end else if (inc) begin
            pc_next   = out + WIDTH'(1);
            wrap_next = &out;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        program_counter_dff_bit #(
            .RESET_BIT(RESET_VECTOR[i])
        ) u_dff (
            .clk  (clk),
            .rst_n(rst_n),
            .d    (pc_next[i]),
            .q    (out[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrapped <= 1'b0;
        end else begin
            wrapped <= wrap_next;
        end
    end

`ifdef PC_TRACE_EN
    // prev_out only captures the old value on edges that actually move out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_out <= RESET_VECTOR;
            changed  <= 1'b0;
        end else begin
            changed <= (pc_next != out);
            if (pc_next != out) begin
                prev_out <= out;
            end
        end
    end
`endif

endmodule

// File: tb/tb_program_counter.sv
// Directed bench for program_counter with an arithmetic reference model checked every cycle.
// Trace outputs are checked too when PC_TRACE_EN is defined.

module tb_program_counter;

    localparam int unsigned WIDTH = 16;
    localparam longint      MODV  = longint'(1) << WIDTH;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] in = '0;
    logic             load = 1'b0;
    logic             inc = 1'b0;
    logic             sreset = 1'b0;
    logic             halt = 1'b0;
    logic [WIDTH-1:0] out;
    logic             wrapped;
`ifdef PC_TRACE_EN
    logic [WIDTH-1:0] prev_out;
    logic             changed;
`endif

    int errors = 0;
    int checks = 0;

    program_counter #(
        .WIDTH       (WIDTH),
        .RESET_VECTOR(16'h0000)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .in     (in),
        .load   (load),
        .inc    (inc),
        .sreset (sreset),
        .halt   (halt),
        .out    (out),
        .wrapped(wrapped)
`ifdef PC_TRACE_EN
        ,
        .prev_out(prev_out),
        .changed (changed)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic over the priority rules.
    longint m_out  = 0;
    bit     m_wrap = 0;
    longint m_prev = 0;
    bit     m_chg  = 0;

    always @(posedge clk or negedge rst_n) begin
        longint nxt;
        if (!rst_n) begin
            m_out = 0; m_wrap = 0; m_prev = 0; m_chg = 0;
        end else begin
            m_wrap = 0;
            if (sreset)    nxt = 0;
            else if (halt) nxt = m_out;
            else if (load) nxt = longint'(in);
            else if (inc) begin
                nxt = (m_out + 1) % MODV;
                m_wrap = (m_out == MODV - 1);
            end else nxt = m_out;
            m_chg = (nxt != m_out);
            if (m_chg) m_prev = m_out;
            m_out = nxt;
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model_out", longint'(out), rst_n ? m_out : 0);
        check("model_wrapped", longint'(wrapped), rst_n ? longint'(m_wrap) : 0);
`ifdef PC_TRACE_EN
        check("model_prev_out", longint'(prev_out), rst_n ? m_prev : 0);
        check("model_changed", longint'(changed), rst_n ? longint'(m_chg) : 0);
`endif
    end

    task automatic drive(input logic [WIDTH-1:0] v_in, input logic v_load, input logic v_inc,
                         input logic v_sreset, input logic v_halt);
        in = v_in; load = v_load; inc = v_inc; sreset = v_sreset; halt = v_halt;
    endtask

    // Apply inputs for one edge, then land on the following negedge.
    task automatic cycle(input logic [WIDTH-1:0] v_in, input logic v_load, input logic v_inc,
                         input logic v_sreset, input logic v_halt);
        drive(v_in, v_load, v_inc, v_sreset, v_halt);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    initial begin
        // Reset held with load active
        drive(16'h1234, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("rst_out", longint'(out), 0);
            check("rst_wrapped", longint'(wrapped), 0);
        end
        rst_n = 1'b1;
        cycle(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0); check("inc1", longint'(out), 1);
        cycle(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0); check("inc2", longint'(out), 2);
        cycle(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0); check("inc3", longint'(out), 3);
        cycle(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0); check("at5", longint'(out), 5);

        // Load beats inc
        cycle(16'h00FF, 1'b1, 1'b1, 1'b0, 1'b0); check("load_over_inc", longint'(out), 16'h00FF);
        cycle(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0); check("inc_carry", longint'(out), 16'h0100);

        // Wrap
        cycle(16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        check("wrap_ffff", longint'(out), 16'hFFFF); check("wrap_ffff_w", longint'(wrapped), 0);
        cycle(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        check("wrap_zero", longint'(out), 0); check("wrap_zero_w", longint'(wrapped), 1);
        cycle(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        check("load0_out", longint'(out), 0); check("load0_w", longint'(wrapped), 0);

        // Halt over load/inc, sreset over halt
        cycle(16'h0040, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(16'h1111, 1'b1, 1'b1, 1'b0, 1'b1);
            check("halt_hold", longint'(out), 16'h0040);
        end
        cycle(16'h1111, 1'b1, 1'b1, 1'b1, 1'b1); check("sreset_over_halt", longint'(out), 0);
        cycle(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0); check("sreset_at_rv", longint'(out), 0);
        cycle(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0); check("idle_hold", longint'(out), 0);

        // Async reset mid-operation
        cycle(16'h000E, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0); check("pre_async", longint'(out), 16'h0010);
        #2 rst_n = 1'b0;
        #1 check("async_now", longint'(out), 0);
        check("async_now_w", longint'(wrapped), 0);
        @(posedge clk); @(posedge clk); #1;
        check("async_held", longint'(out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0); check("post_async", longint'(out), 1);

        // Trace behaviour
        cycle(16'h0007, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(16'h0020, 1'b1, 1'b0, 1'b0, 1'b0); check("trace_load", longint'(out), 16'h0020);
`ifdef PC_TRACE_EN
        check("trace_prev", longint'(prev_out), 7); check("trace_chg", longint'(changed), 1);
`endif
        cycle(16'h0000, 1'b0, 1'b1, 1'b0, 1'b1); check("trace_halt", longint'(out), 16'h0020);
`ifdef PC_TRACE_EN
        check("trace_prev_hold", longint'(prev_out), 7); check("trace_chg0", longint'(changed), 0);
`endif
        cycle(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef PC_TRACE_EN
        check("trace_sreset_rv", longint'(changed), 0);
`endif
        drive(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
